gumnut_port_timer: RTL

Programmable interval timer that sits on the Gumnut core's I/O port bus as a responder and drives the core's interrupt request line. The core reads and writes four byte registers through port accesses. The timer raises `int_req_o` on expiry and drops it when the core returns `int_ack`. It is the slave side of the port and interrupt handshakes the core initiates.

---
 rtl/gumnut_port_timer.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/gumnut_port_timer.sv
// gumnut_port_timer: programmable interval timer on the Gumnut I/O port bus.
// Four byte registers at BASE_ADDR..BASE_ADDR+3 (CTRL, RELOAD, COUNT, STATUS).
// A prescaler divides clk by PRESCALE into ticks that decrement COUNT; on
// expiry STATUS.EXP is set and int_req_o follows EXP & IE.
// Optional feature macro: GUMNUT_TIMER_OVERRUN_EN adds the STATUS.OVR flag.
module gumnut_port_timer #(
    parameter logic [7:0]  BASE_ADDR = 8'h10,
    parameter int unsigned PRESCALE  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       port_cyc_i,
    input  logic       port_stb_i,
    input  logic       port_we_i,
    input  logic [7:0] port_adr_i,
    input  logic [7:0] port_dat_i,
    output logic [7:0] port_dat_o,
    output logic       port_ack_o,
    output logic       int_req_o,
    input  logic       int_ack_i
);

    localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PsW-1:0] PsMax = PsW'(PRESCALE - 1);

    localparam logic [1:0] OffCtrl   = 2'd0;
    localparam logic [1:0] OffReload = 2'd1;
    localparam logic [1:0] OffCount  = 2'd2;
    localparam logic [1:0] OffStatus = 2'd3;

    // Bus-side state
    logic       ack_q, ack_d;
    logic [7:0] dat_q, dat_d;

    // Timer state
    logic           en_q, en_d;
    logic           auto_q, auto_d;
    logic           ie_q, ie_d;
    logic [7:0]     reload_q, reload_d;
    logic [7:0]     count_q, count_d;
    logic [PsW-1:0] ps_q, ps_d;
    logic           exp_q, exp_d;
    logic           ovr_rd;

    // Decoded access strobes
    logic       sel;
    logic       access;
    logic       wr;
    logic [1:0] offset;
    logic       wr_ctrl, wr_reload, wr_status;
    logic       tick;
    logic       expire;
    logic [7:0] rdata;

    // Address decode and the one-access-per-ack handshake
    always_comb begin
        sel       = port_cyc_i & port_stb_i & (port_adr_i[7:2] == BASE_ADDR[7:2]);
        access    = sel & ~ack_q;
        wr        = access & port_we_i;
        offset    = port_adr_i[1:0];
        wr_ctrl   = wr & (offset == OffCtrl);
        wr_reload = wr & (offset == OffReload);
        wr_status = wr & (offset == OffStatus);
    end

    // Read mux over current (pre-edge) register state
    always_comb begin
        rdata = 8'h00;
        unique case (offset)
            OffCtrl:   rdata = {5'b00000, ie_q, auto_q, en_q};
            OffReload: rdata = reload_q;
            OffCount:  rdata = count_q;
            OffStatus: rdata = {6'b000000, ovr_rd, exp_q};
            default:   rdata = 8'h00;
        endcase
    end

    // Ack and read data are registered together; data is zero outside an ack
    always_comb begin
        ack_d = access;
        dat_d = (access & ~port_we_i) ? rdata : 8'h00;
    end

    // Prescaler: free-runs while EN stays 1, otherwise parked at 0
    always_comb begin
        tick = en_q & (ps_q == PsMax);
        if (en_q && en_d && !tick) begin
            ps_d = ps_q + PsW'(1);
        end else begin
            ps_d = '0;
        end
    end

    // Control registers and down-counter; bus writes first, then tick effects
    always_comb begin
        en_d     = en_q;
        auto_d   = auto_q;
        ie_d     = ie_q;
        reload_d = reload_q;
        count_d  = count_q;
        expire   = 1'b0;

        if (wr_ctrl) begin
            en_d   = port_dat_i[0];
            auto_d = port_dat_i[1];
            ie_d   = port_dat_i[2];
            // Enable edge restarts a full period
            if (!en_q && port_dat_i[0]) begin
                count_d = reload_q;
            end
        end

        if (wr_reload) begin
            reload_d = port_dat_i;
            if (!en_q) begin
                count_d = port_dat_i;
            end
        end

        if (tick) begin
            if (count_q <= 8'd1) begin
                expire  = 1'b1;
                count_d = reload_q;
                // A CTRL write on the same edge keeps its EN value
                if (!auto_q && !wr_ctrl) begin
                    en_d = 1'b0;
                end
            end else begin
                count_d = count_q - 8'd1;
            end
        end
    end

    // EXP flag: clears first so a coincident expiry wins
    always_comb begin
        exp_d = exp_q;
        if (wr_status && port_dat_i[0]) begin
            exp_d = 1'b0;
        end
        if (int_ack_i) begin
            exp_d = 1'b0;
        end
        if (expire) begin
            exp_d = 1'b1;
        end
    end

`ifdef GUMNUT_TIMER_OVERRUN_EN
    logic ovr_q, ovr_d;

    // OVR flag: expiry with EXP still pending; only a STATUS write clears it
    always_comb begin
        ovr_d = ovr_q;
        if (wr_status && port_dat_i[1]) begin
            ovr_d = 1'b0;
        end
        if (expire && exp_q) begin
            ovr_d = 1'b1;
        end
    end

    // OVR register
    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign ovr_rd = ovr_q;
`else
    assign ovr_rd = 1'b0;
`endif

    // State registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q    <= 1'b0;
            dat_q    <= 8'h00;
            en_q     <= 1'b0;
            auto_q   <= 1'b0;
            ie_q     <= 1'b0;
            reload_q <= 8'h00;
            count_q  <= 8'h00;
            ps_q     <= '0;
            exp_q    <= 1'b0;
        end else begin
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            en_q     <= en_d;
            auto_q   <= auto_d;
            ie_q     <= ie_d;
            reload_q <= reload_d;
            count_q  <= count_d;
            ps_q     <= ps_d;
            exp_q    <= exp_d;
        end
    end

    // Outputs straight from registered state
    always_comb begin
        port_ack_o = ack_q;
        port_dat_o = dat_q;
        int_req_o  = exp_q & ie_q;
    end

endmodule
